// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands in a FIFO, drives the external
// combinational ALU from the FIFO head and registers results.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   cmd_*             - command input (valid/ready, a, b, op)
//   alu_a/b/aluc      - drive to ALU; alu_s is the ALU result
//   res_*             - registered result (valid/ready, s, op, zero)
//   fifo_count        - entries currently queued
module alu_cmd_issuer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_a,
  input  logic [31:0]              cmd_b,
  input  logic [1:0]               cmd_op,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [1:0]               alu_aluc,
  input  logic [31:0]              alu_s,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_s,
  output logic [1:0]               res_op,
  output logic                     res_zero,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          res_valid_q, res_valid_d;
  logic [31:0]   res_s_q, res_s_d;
  logic [1:0]    res_op_q, res_op_d;
  logic          res_zero_q, res_zero_d;

  logic  empty;
  logic  push;
  logic  issue;
  cmd_t  head;

  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // No pass-through when full: a same-cycle pop does not free a slot.
  assign cmd_ready = !rst && (count_q < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign issue     = !empty && (!res_valid_q || res_ready);

  assign alu_a    = empty ? 32'd0 : head.a;
  assign alu_b    = empty ? 32'd0 : head.b;
  assign alu_aluc = empty ? 2'd0  : head.op;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(issue);
    res_valid_d = res_valid_q;
    res_s_d     = res_s_q;
    res_op_d    = res_op_q;
    res_zero_d  = res_zero_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{a: cmd_a, b: cmd_b, op: cmd_op};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (issue) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      res_valid_d = 1'b1;
      res_s_d     = alu_s;
      res_op_d    = head.op;
      res_zero_d  = (alu_s == 32'd0);
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_s_q     <= '0;
      res_op_q    <= '0;
      res_zero_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_s_q     <= res_s_d;
      res_op_q    <= res_op_d;
      res_zero_q  <= res_zero_d;
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign res_valid  = res_valid_q;
  assign res_s      = res_s_q;
  assign res_op     = res_op_q;
  assign res_zero   = res_zero_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: table vectors plus backpressure, streaming and
// reset sequences; results checked against a queue of expectations.
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [1:0]  cmd_op;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_aluc;
  logic [31:0] alu_s;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_s;
  logic [1:0]  res_op;
  logic        res_zero;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_s(alu_s),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_s(res_s), .res_op(res_op), .res_zero(res_zero),
    .fifo_count(fifo_count)
  );

  function automatic logic [31:0] ref_alu(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a + b;
      default: return a - b;
    endcase
  endfunction

  // External combinational ALU.
  always_comb alu_s = ref_alu(alu_a, alu_b, alu_aluc);

  typedef struct {
    logic [31:0] s;
    logic [1:0]  op;
    logic        z;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] s;
    logic        z;
  } vec_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   vectors = 0;
  int   miscompares = 0;
  bit   accepted;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge (scoreboard), then edge, then settle.
  task automatic step();
    exp_t e;
    @(negedge clk);
    accepted = 1'b0;
    if (rst) begin
      sb.delete();
    end else begin
      if (res_valid && res_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_result: got s=%h op=%0d", res_s, res_op);
        end else begin
          e = sb.pop_front();
          if (res_s !== e.s || res_op !== e.op || res_zero !== e.z) begin
            miscompares++;
            $display("FAIL result: got s=%h op=%0d z=%b expected s=%h op=%0d z=%b",
                     res_s, res_op, res_zero, e.s, e.op, e.z);
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        sb.push_back(cur_exp);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] s,
                          input logic z);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cur_exp = '{s: s, op: op, z: z};
    for (int i = 0; i < 20; i++) begin
      step();
      if (accepted) break;
    end
    if (!accepted) chk("push_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic push_ref(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op);
    logic [31:0] s;
    s = ref_alu(a, b, op);
    push_exp(a, b, op, s, s == 32'd0);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  vec_t vt [8];
  logic [31:0] exp1;

  initial begin
    vt[0] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b00, 32'h00F0_00F0, 1'b0};
    vt[1] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b01, 32'hFFF0_FFF0, 1'b0};
    vt[2] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b10, 32'h00E1_00E0, 1'b0};
    vt[3] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b11, 32'hE100_E100, 1'b0};
    vt[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b10, 32'h0000_0000, 1'b1};
    vt[5] = '{32'h0000_0000, 32'h0000_0001, 2'b11, 32'hFFFF_FFFF, 1'b0};
    vt[6] = '{32'hAAAA_5555, 32'h5555_AAAA, 2'b00, 32'h0000_0000, 1'b1};
    vt[7] = '{32'h1234_5678, 32'h1234_5678, 2'b11, 32'h0000_0000, 1'b1};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_op = '0;
    res_ready = 1'b0;
    cur_exp = '{s: '0, op: '0, z: 1'b0};

    // Reset state
    step();
    step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_res_valid", 32'(res_valid), 32'd0);
    chk("post_rst_count", 32'(fifo_count), 32'd0);
    chk("post_rst_alu_a", alu_a, 32'd0);
    chk("post_rst_alu_b", alu_b, 32'd0);
    chk("post_rst_aluc", 32'(alu_aluc), 32'd0);
    chk("post_rst_res_s", res_s, 32'd0);
    chk("post_rst_res_op", 32'(res_op), 32'd0);
    chk("post_rst_res_zero", 32'(res_zero), 32'd0);

    // Single op latency
    res_ready = 1'b1;
    push_exp(32'h0000_000F, 32'h0000_0003, 2'b10, 32'h0000_0012, 1'b0);
    chk("single_count", 32'(fifo_count), 32'd1);
    chk("single_valid_early", 32'(res_valid), 32'd0);
    chk("single_alu_a", alu_a, 32'h0000_000F);
    chk("single_aluc", 32'(alu_aluc), 32'd2);
    step();
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_res_s", res_s, 32'h0000_0012);
    chk("single_res_op", 32'(res_op), 32'd2);
    chk("single_res_zero", 32'(res_zero), 32'd0);
    drain(5);

    // Table vectors back-to-back
    for (int i = 0; i < 8; i++) begin
      push_exp(vt[i].a, vt[i].b, vt[i].op, vt[i].s, vt[i].z);
      if (i > 0) chk("throughput_valid", 32'(res_valid), 32'd1);
    end
    drain(10);

    // Backpressure to full
    res_ready = 1'b0;
    for (int i = 1; i <= 5; i++)
      push_ref(32'h1000_0000 * i + i, 32'(i), 2'(i));
    exp1 = ref_alu(32'h1000_0001, 32'd1, 2'd1);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("full_res_valid", 32'(res_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_res_s", res_s, exp1);
      chk("stall_count", 32'(fifo_count), 32'd4);
    end
    res_ready = 1'b1;
    #1;
    chk("release_cmd_ready_lo", 32'(cmd_ready), 32'd0);
    step();
    chk("release_cmd_ready_hi", 32'(cmd_ready), 32'd1);
    chk("release_count", 32'(fifo_count), 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(res_valid), 32'd1);
      step();
    end
    drain(5);

    // Simultaneous push/pop at steady count 2
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_ref($urandom, $urandom, 2'(i));
    chk("steady_count_init", 32'(fifo_count), 32'd2);
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_ref($urandom, $urandom, 2'($urandom_range(0, 3)));
      chk("steady_count", 32'(fifo_count), 32'd2);
    end
    drain(20);

    // Reset mid-stream
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_ref(32'hDEAD_0000 + i, 32'd7, 2'd2);
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    chk("pre_rst_valid", 32'(res_valid), 32'd1);
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_a = 32'hBAD0_BAD0;
    step();
    rst = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("no_stale_valid", 32'(res_valid), 32'd0);
    push_ref(32'h0000_0005, 32'h0000_0005, 2'b11);
    drain(5);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Request-side sequencer for the combinational 32-bit ALU (ops: AND, OR, ADD, SUB). Accepts operand/opcode commands through a valid/ready port, buffers them in a small FIFO, presents one command per cycle to the ALU's `a`/`b`/`aluc` inputs, and registers the returned `s` into a result port with its own valid/ready backpressure. It sits between the instruction sequencer and the ALU, decoupling command issue from result consumption.

## Interface
- `DEPTH`, 4, command FIFO entries; must be a power of 2, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: **one clock; reset is synchronous and active-high.**
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept a command this cycle.
- `cmd_a` in 32: operand a.
- `cmd_b` in 32: operand b.
- `cmd_op` in 2: 00 AND, 01 OR, 10 ADD, 11 SUB (a−b).
- `alu_a` out 32: drives ALU `a`.
- `alu_b` out 32: drives ALU `b`.
- `alu_aluc` out 2: drives ALU `aluc`.
- `alu_s` in 32: ALU result, combinational from `alu_a`/`alu_b`/`alu_aluc`.
- `res_valid` out 1: result register holds an unconsumed result.
- `res_ready` in 1: consumer takes result this cycle.
- `res_s` out 32: registered result.
- `res_op` out 2: opcode that produced `res_s`.
- `res_zero` out 1: `res_s == 0`, registered with `res_s`.
- `fifo_count` out $clog2(DEPTH)+1: entries held in the FIFO.

## Operation
- Command FIFO: circular buffer, `wr_ptr`/`rd_ptr` wrap modulo DEPTH, and `count` in 0..DEPTH.
- Push when `cmd_valid && cmd_ready`.
- `cmd_ready = !rst && (count < DEPTH)`. There is no pass-through when full, even if a pop happens the same cycle.
- ALU drive:
  - FIFO non-empty: `alu_a/alu_b/alu_aluc` = head entry, combinationally.
  - FIFO empty: all three drive 0.
- Issue condition: `issue = (count != 0) && (!res_valid || res_ready)`.
- On issue at an edge:
  - `res_s <= alu_s`, `res_op <= head op`, `res_zero <= (alu_s == 0)`, `res_valid <= 1`.
  - Pop the head.
- `res_ready && res_valid && !issue` → `res_valid <= 0`. The data registers hold their value.
- `res_valid && !res_ready` → result registers, `res_op` and `res_zero` hold, and the FIFO does not pop.
- Simultaneous push and pop (count not full): count unchanged, both pointers advance.
- Commands are issued strictly in order; none is dropped or duplicated.
- Arithmetic is performed by the ALU. The block neither checks nor modifies it. ADD/SUB wrap modulo 2^32 and no carry/overflow is reported.

## Timing
- Reset (`rst` high at an edge) clears:
  - `count` and both pointers to 0.
  - `res_valid` to 0; `res_s`, `res_op`, `res_zero` to 0.
- Reset values of the remaining outputs:
  - `cmd_ready` 0 while `rst` is high; 1 in the first cycle after deassertion.
  - `alu_a/b/aluc` 0 and `fifo_count` 0.
- Reset mid-operation discards all queued commands and any pending result. Inputs sampled during reset are ignored.
- Latency: command pushed at edge N into an empty FIFO with a free result register → issued at edge N+1 → `res_valid` high after edge N+1.
- Throughput: one result per cycle while `res_ready` stays high and the FIFO is non-empty.
- Full FIFO, `res_ready` low: `cmd_ready` 0. The first `res_ready` cycle issues one entry; `cmd_ready` rises the following cycle.
- All outputs except `alu_a/b/aluc` and `cmd_ready` are registered.

## Test plan
- **Single op:** push a=0x0000_000F, b=0x0000_0003, op=10 → one cycle later `res_valid`=1, `res_s`=0x0000_0012, `res_op`=10, `res_zero`=0.
- **All opcodes back-to-back** with `res_ready`=1: a=0xF0F0_F0F0, b=0x0FF0_0FF0 → results in order:
  - AND 0x00F0_00F0
  - OR 0xFFF0_FFF0
  - ADD 0x00E1_00E0
  - SUB 0xE100_E100
  - Expect one result per cycle.
- **Wrap and zero:** ADD 0xFFFF_FFFF+1 → `res_s`=0, `res_zero`=1. SUB 0−1 → 0xFFFF_FFFF.
- **Backpressure/full:** hold `res_ready`=0 and push 5 commands (DEPTH=4).
  - 1st fills the result register; 4 more fill the FIFO; `cmd_ready`=0 and `fifo_count`=4.
  - `res_s` is stable throughout.
  - Release `res_ready` → remaining 4 results drain in order, one per cycle.
- **Simultaneous push/pop:** hold `fifo_count`=2 while streaming with `res_ready`=1 → `fifo_count` stays 2 and pointers wrap past DEPTH with no loss.
- **Reset mid-stream:** assert `rst` for one cycle with 3 queued commands and `res_valid`=1.
  - Next cycle: `res_valid`=0, `fifo_count`=0, `alu_a`=0, `cmd_ready`=1.
  - No stale result appears afterwards.
